// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
//   Shared definitions for the register-file dump transmitter.
//   - state_t      : FSM state encoding used by regfile_dump_tx
//   - Def*         : default geometry (8 registers of 8 bits, 16 clk/bit)
//   - NumRegs      : number of registers walked with the default geometry
//   - FrameBits    : serial bits per frame (start + data + stop)
//   - frame_cycles : clk cycles one register occupies, LOAD cycle included
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

    localparam int DefRegBits    = 3;
    localparam int DefWordSize   = 8;
    localparam int DefClksPerBit = 16;

    localparam int NumRegs   = 1 << DefRegBits;
    localparam int FrameBits = DefWordSize + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int frame_cycles(input int word_size, input int clks_per_bit);
        return 1 + (word_size + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/regfile_dump_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
//   Serial bit-time generator: a down-counter that spans ClksPerBit clk cycles.
//   Ports:
//     clk   - clock
//     reset - synchronous, active-low reset (counter cleared to 0)
//     load  - restart the bit period; the following ClksPerBit cycles form
//             one full bit time
//     tick  - high in the last cycle of each bit time
//   After a tick the counter reloads itself, so consecutive bits follow with
//   no gap and the owner only has to pulse load once per frame.
// -----------------------------------------------------------------------------
module tx_bit_timer #(
    parameter int ClksPerBit = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load || count == '0) begin
            count <= Reload;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/regfile_dump_tx.sv
// -----------------------------------------------------------------------------
// regfile_dump_tx
//   Walks every register of a register file through one read port and sends
//   each value as an asynchronous serial frame (start 0, data LSB first,
//   stop 1), lowest register first.
//   Ports:
//     clk    - clock, all state changes on the rising edge
//     reset  - synchronous, active-low reset; aborts a dump in progress
//     start  - request a full dump, only looked at while idle
//     rdreg  - register select to the register-file read port
//     rddata - combinational read data for rdreg
//     txd    - serial line, idles high
//     busy   - high whenever a dump is in progress
//     done   - one-cycle pulse after the last register's stop bit
//   Each register is captured during its own LOAD cycle, so the dump is not an
//   atomic snapshot of the whole file.
// -----------------------------------------------------------------------------
module regfile_dump_tx
    import regfile_dump_pkg::*;
#(
    parameter int RegBits    = DefRegBits,
    parameter int WordSize   = DefWordSize,
    parameter int ClksPerBit = DefClksPerBit
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [RegBits-1:0]  rdreg,
    input  logic [WordSize-1:0] rddata,
    output logic                txd,
    output logic                busy,
    output logic                done
);

    localparam int BitW = $clog2(WordSize + 1);
    localparam logic [RegBits-1:0] LastReg = '1;
    localparam logic [BitW-1:0]    LastBit = BitW'(WordSize - 1);

    state_t              state;
    logic [RegBits-1:0]  regidx;
    logic [WordSize-1:0] shifter;
    logic [BitW-1:0]     bit_cnt;
    logic                bit_tick;
    logic                timer_load;

    // The timer is restarted in LOAD so the start bit gets a full bit time.
    assign timer_load = (state == LOAD);

    tx_bit_timer #(
        .ClksPerBit(ClksPerBit)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            regidx  <= '0;
            // NOTE: the shifter is datapath and could skip reset, but it is
            // cleared so a reset leaves the block in one fully known state.
            shifter <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        regidx <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    shifter <= rddata;
                    state   <= START;
                end
                START: begin
                    if (bit_tick) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shifter <= shifter >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LastBit) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (regidx == LastReg) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            regidx <= regidx + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: txd gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        txd = 1'b1;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shifter[0];
            default: txd = 1'b1;
        endcase
    end

    assign busy  = (state != IDLE);
    assign rdreg = regidx;

endmodule
